// File: rtl/alu_pkg.sv
// Shared encodings for the 3-bit ALU command sequencer.
package alu_pkg;

  localparam int ALU_WIDTH = 3;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'b00;
  localparam state_t EXEC = 2'b01;
  localparam state_t RESP = 2'b10;

endpackage

// File: rtl/alu_op_sequencer.sv
// Command/result sequencer around an external 3-bit ALU.
// Optional accumulator source for operand A under ALU_SEQ_ACCUM_EN.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  output logic [WIDTH-1:0] alu_in_0,
  output logic [WIDTH-1:0] alu_in_1,
  output logic             alu_m_0,
  output logic             alu_m_1,
  output logic             alu_c_in,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_c_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_cout,
  output logic             res_zero,
  output logic [CNT_W-1:0] op_count
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] in0_q, in1_q;
  logic [1:0]       m_q;
  logic [WIDTH-1:0] data_q;
  logic             cout_q, zero_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sel;
  logic             accept, done;

  assign accept = (state_q == IDLE) && cmd_valid;
  assign done   = (state_q == RESP) && res_ready;

`ifdef ALU_SEQ_ACCUM_EN
  logic [WIDTH-1:0] acc_q;

  always_ff @(posedge clk) begin
    if (rst)       acc_q <= '0;
    else if (done) acc_q <= data_q;
  end

  assign a_sel = cmd_use_acc ? acc_q : cmd_a;
`else
  // Without the accumulator the select input has no effect.
  assign a_sel = cmd_a | {WIDTH{cmd_use_acc & 1'b0}};
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      in0_q   <= '0;
      in1_q   <= '0;
      m_q     <= '0;
      data_q  <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        in0_q <= a_sel;
        in1_q <= cmd_b;
        m_q   <= cmd_op;
      end
      // Logic ops carry no meaningful carry out.
      if (state_q == EXEC) begin
        data_q <= alu_out;
        cout_q <= alu_c_out & ~m_q[1];
        zero_q <= (alu_out == '0);
      end
      if (done) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign res_valid = (state_q == RESP);
  assign alu_in_0  = in0_q;
  assign alu_in_1  = in1_q;
  assign alu_m_0   = m_q[0];
  assign alu_m_1   = m_q[1];
  assign alu_c_in  = 1'b0;
  assign res_data  = data_q;
  assign res_cout  = cout_q;
  assign res_zero  = zero_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU beside it.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int W  = 3;
  localparam int CW = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         c;
    logic         z;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [W-1:0]  cmd_a, cmd_b;
  logic          cmd_use_acc;
  logic [W-1:0]  alu_in_0, alu_in_1;
  logic          alu_m_0, alu_m_1, alu_c_in;
  logic [W-1:0]  alu_out;
  logic          alu_c_out;
  logic          res_valid, res_ready;
  logic [W-1:0]  res_data;
  logic          res_cout, res_zero;
  logic [CW-1:0] op_count;

  int            n_cmp = 0;
  int            n_err = 0;
  exp_t          q[$];
  logic [CW-1:0] cnt_m = '0;
  logic [W-1:0]  acc_m = '0;
  logic          rr_rand = 1'b0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_use_acc(cmd_use_acc),
    .alu_in_0(alu_in_0), .alu_in_1(alu_in_1),
    .alu_m_0(alu_m_0), .alu_m_1(alu_m_1), .alu_c_in(alu_c_in),
    .alu_out(alu_out), .alu_c_out(alu_c_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_cout(res_cout), .res_zero(res_zero),
    .op_count(op_count)
  );

  // Behavioural ALU; logic ops drive a junk carry of 1.
  logic [3:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    case ({alu_m_1, alu_m_0})
      2'b00:   alu_sum = {1'b0, alu_in_0} + {1'b0, alu_in_1} + {3'b0, alu_c_in};
      2'b01:   alu_sum = {1'b0, alu_in_0} - {1'b0, alu_in_1} - {3'b0, alu_c_in};
      2'b10:   alu_sum = {1'b1, alu_in_0 & alu_in_1};
      default: alu_sum = {1'b1, alu_in_0 ^ alu_in_1};
    endcase
  end
  assign alu_out   = alu_sum[2:0];
  assign alu_c_out = alu_sum[3];

  function automatic exp_t ref_op(input int op, input int a, input int b);
    exp_t e;
    int   r;
    logic c;
    case (op)
      0:       begin r = a + b; c = (r > 7); end
      1:       begin r = a - b; c = (a < b); end
      2:       begin r = a & b; c = 1'b0; end
      default: begin r = a ^ b; c = 1'b0; end
    endcase
    e.d = W'(r & 7);
    e.c = c;
    e.z = ((r & 7) == 0);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_alu_in_0", 32'(alu_in_0), 0);
    chk("rst_alu_in_1", 32'(alu_in_1), 0);
    chk("rst_alu_m", 32'({alu_m_1, alu_m_0}), 0);
    chk("rst_alu_c_in", 32'(alu_c_in), 0);
    chk("rst_res_data", 32'(res_data), 0);
    chk("rst_res_cout", 32'(res_cout), 0);
    chk("rst_res_zero", 32'(res_zero), 0);
    chk("rst_op_count", 32'(op_count), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    q.delete();
    cnt_m = '0;
    acc_m = '0;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic ua);
    logic [W-1:0] ea;
    int           t;
    @(posedge clk); #2;
    cmd_valid = 1'b1;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
    @(negedge clk);
    t = 0;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: got cmd_ready=0 expected 1");
      cmd_valid = 1'b0;
      return;
    end
    ea = a;
`ifdef ALU_SEQ_ACCUM_EN
    if (ua) ea = acc_m;
`endif
    q.push_back(ref_op(int'(op), int'(ea), int'(b)));
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    cmd_a = W'($urandom);
    cmd_b = W'($urandom);
    @(negedge clk);
    chk("exec_alu_in_0", 32'(alu_in_0), 32'(ea));
    chk("exec_alu_in_1", 32'(alu_in_1), 32'(b));
    chk("exec_alu_m", 32'({alu_m_1, alu_m_0}), 32'(op));
    chk("exec_alu_c_in", 32'(alu_c_in), 0);
    chk("exec_cmd_ready", 32'(cmd_ready), 0);
    chk("exec_res_valid", 32'(res_valid), 0);
    @(negedge clk);
    chk("latency_res_valid", 32'(res_valid), 1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && res_valid && res_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_result: got res_data=%0d expected none",
                   res_data);
        end else begin
          e = q.pop_front();
          chk("res_data", 32'(res_data), 32'(e.d));
          chk("res_cout", 32'(res_cout), 32'(e.c));
          chk("res_zero", 32'(res_zero), 32'(e.z));
          chk("op_count", 32'(op_count), 32'(cnt_m));
          cnt_m = cnt_m + 1'b1;
          acc_m = e.d;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #2;
      if (rr_rand) res_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_use_acc = 1'b0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #2;
    rst = 1'b0;

    // Reset while an add 1+1 is executing: dropped, counter stays 0.
    @(posedge clk); #2;
    cmd_valid = 1'b1; cmd_op = ALU_ADD; cmd_a = 3'd1; cmd_b = 3'd1;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rstexec_in_exec", 32'(cmd_ready), 0);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #2;
    rst = 1'b0;

    send(ALU_ADD, 3'd3, 3'd5, 1'b0);
    @(negedge clk);
    chk("first_op_count", 32'(op_count), 1);
    send(ALU_AND, 3'd6, 3'd3, 1'b0);
    send(ALU_XOR, 3'd5, 3'd5, 1'b0);
    send(ALU_SUB, 3'd2, 3'd5, 1'b0);
    send(ALU_SUB, 3'd6, 3'd1, 1'b0);
    send(ALU_ADD, 3'd7, 3'd7, 1'b0);

    // Backpressure with stray command pulses.
    @(posedge clk); #2;
    res_ready = 1'b0;
    send(ALU_AND, 3'd7, 3'd5, 1'b0);
    e = q[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      cmd_valid = ~i[0];
      cmd_op = ALU_ADD; cmd_a = 3'd7; cmd_b = 3'd7;
      @(negedge clk);
      chk("bp_res_valid", 32'(res_valid), 1);
      chk("bp_res_data", 32'(res_data), 32'(e.d));
      chk("bp_res_cout", 32'(res_cout), 32'(e.c));
      chk("bp_cmd_ready", 32'(cmd_ready), 0);
    end
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_not_consumed_ready", 32'(cmd_ready), 1);
    chk("bp_not_consumed_valid", 32'(res_valid), 0);
    chk("bp_queue_empty", 32'(q.size()), 0);

`ifdef ALU_SEQ_ACCUM_EN
    send(ALU_ADD, 3'd1, 3'd1, 1'b0);
    send(ALU_ADD, 3'd6, 3'd3, 1'b1);
    chk("acc_alu_in_0", 32'(alu_in_0), 2);
    chk("acc_res_data", 32'(res_data), 5);
    chk("acc_res_cout", 32'(res_cout), 0);
`endif

    rr_rand = 1'b1;
    for (int i = 0; i < 300; i++)
      send(2'($urandom), W'($urandom), W'($urandom), 1'($urandom));

    @(posedge clk); #2;
    rr_rand = 1'b0;
    res_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 256; i++)
      send(2'($urandom), W'($urandom), W'($urandom), 1'($urandom));
    @(negedge clk);
    chk("wrap_op_count", 32'(op_count), 0);

    for (int t = 0; t < 50 && q.size() != 0; t++) @(negedge clk);
    chk("final_queue_empty", 32'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
